decode_issue: RTL

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/decode_issue_pkg.sv | 72 +++++++
 rtl/decode_issue_regfile.sv | 51 +++++
 rtl/decode_issue.sv | 125 ++++++++++++
 3 files changed

// File: rtl/decode_issue_pkg.sv
// rtl/decode_issue_pkg.sv - opcode, field and register-file constants for decode_issue
//
// Shared by decode_issue and decode_issue_regfile.
// Holds opcode encodings, instruction-word field positions,
// register count/width constants and per-opcode lookup functions.

package decode_issue_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int RIDX_W = 5;

    // Instruction word field positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 24;
    localparam int RD_HI  = 23;
    localparam int RD_LO  = 19;
    localparam int RA_HI  = 18;
    localparam int RA_LO  = 14;
    localparam int RB_HI  = 13;
    localparam int RB_LO  = 9;
    localparam int OFF_HI = 13;
    localparam int OFF_LO = 0;
    localparam int OFF_W  = 14;

    localparam logic [7:0] OP_ADD      = 8'h00;
    localparam logic [7:0] OP_SUB      = 8'h01;
    localparam logic [7:0] OP_MUL      = 8'h02;
    localparam logic [7:0] OP_LDB      = 8'h10;
    localparam logic [7:0] OP_LDW      = 8'h11;
    localparam logic [7:0] OP_STB      = 8'h12;
    localparam logic [7:0] OP_STW      = 8'h13;
    localparam logic [7:0] OP_MOV      = 8'h14;
    localparam logic [7:0] OP_BEQ      = 8'h30;
    localparam logic [7:0] OP_JUMP     = 8'h31;
    localparam logic [7:0] OP_TLBWRITE = 8'h32;
    localparam logic [7:0] OP_IRET     = 8'h33;

    // Number of extra ALU cycles a mul occupies after its handshake
    localparam logic [1:0] MUL_HOLD = 2'd2;

    // Source of the second ALU operand
    typedef enum logic [1:0] {
        SRC2_REG  = 2'd0,
        SRC2_IMM  = 2'd1,
        SRC2_ZERO = 2'd2
    } src2_e;

    function automatic logic op_wb_en(input logic [7:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_LDB, OP_LDW, OP_MOV: op_wb_en = 1'b1;
            default:                                         op_wb_en = 1'b0;
        endcase
    endfunction

    function automatic logic op_legal(input logic [7:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_LDB, OP_LDW, OP_STB, OP_STW, OP_MOV,
            OP_BEQ, OP_JUMP, OP_TLBWRITE, OP_IRET: op_legal = 1'b1;
            default:                               op_legal = 1'b0;
        endcase
    endfunction

    function automatic src2_e op_src2(input logic [7:0] op);
        case (op)
            OP_LDB, OP_LDW, OP_STB, OP_STW, OP_JUMP: op_src2 = SRC2_IMM;
            OP_MOV:                                  op_src2 = SRC2_ZERO;
            default:                                 op_src2 = SRC2_REG;
        endcase
    endfunction

endpackage

// File: rtl/decode_issue_regfile.sv
// rtl/decode_issue_regfile.sv - 32x32 register file, 3 read ports, 1 write port with bypass
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset (clears all registers)
//   wr_en, wr_idx, wr_data write port; writes to index 0 are ignored
//   rd_idx0..2             combinational read addresses
//   rd_data0..2            read data; index 0 reads 0, same-cycle write is bypassed

module decode_issue_regfile
    import decode_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [RIDX_W-1:0] wr_idx,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [RIDX_W-1:0] rd_idx0,
    input  logic [RIDX_W-1:0] rd_idx1,
    input  logic [RIDX_W-1:0] rd_idx2,
    output logic [XLEN-1:0]   rd_data0,
    output logic [XLEN-1:0]   rd_data1,
    output logic [XLEN-1:0]   rd_data2
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && (wr_idx != '0)) begin
            mem[wr_idx] <= wr_data;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [RIDX_W-1:0] idx);
        if (idx == '0) begin
            read_port = '0;
        end else if (wr_en && (wr_idx == idx)) begin
            read_port = wr_data;
        end else begin
            read_port = mem[idx];
        end
    endfunction

    assign rd_data0 = read_port(rd_idx0);
    assign rd_data1 = read_port(rd_idx1);
    assign rd_data2 = read_port(rd_idx2);

endmodule

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - instruction decode and single-entry issue register toward the ALU
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in_valid_i, in_instr_i, in_ready_o instruction input handshake
//   flush_i                           drop the held, unissued bundle
//   out_valid_o, out_ready_i          issue bundle handshake
//   instr_o, val1_o, val2_o           ALU opcode and operands
//   store_data_o, rd_o, wb_en_o       R[rd], destination index, writeback enable
//   wb_valid_i, wb_idx_i, wb_data_i   register-file write port
//   illegal_o                         one-cycle pulse when an undefined opcode is dropped

module decode_issue
    import decode_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [31:0]       in_instr_i,
    output logic              in_ready_o,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [7:0]        instr_o,
    output logic [XLEN-1:0]   val1_o,
    output logic [XLEN-1:0]   val2_o,
    output logic [XLEN-1:0]   store_data_o,
    output logic [RIDX_W-1:0] rd_o,
    output logic              wb_en_o,
    input  logic              wb_valid_i,
    input  logic [RIDX_W-1:0] wb_idx_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              illegal_o
);

    logic [7:0]        opc;
    logic [RIDX_W-1:0] f_rd, f_ra, f_rb;
    logic [OFF_W-1:0]  f_off;
    logic [XLEN-1:0]   ra_data, rb_data, rd_data;
    logic [XLEN-1:0]   next_val2;

    logic [1:0]        hold_cnt;
    logic              vld_q;
    logic              busy;
    logic              accept;
    logic              handshake;

    assign opc   = in_instr_i[OPC_HI:OPC_LO];
    assign f_rd  = in_instr_i[RD_HI:RD_LO];
    assign f_ra  = in_instr_i[RA_HI:RA_LO];
    assign f_rb  = in_instr_i[RB_HI:RB_LO];
    assign f_off = in_instr_i[OFF_HI:OFF_LO];

    decode_issue_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wb_valid_i),
        .wr_idx   (wb_idx_i),
        .wr_data  (wb_data_i),
        .rd_idx0  (f_ra),
        .rd_idx1  (f_rb),
        .rd_idx2  (f_rd),
        .rd_data0 (ra_data),
        .rd_data1 (rb_data),
        .rd_data2 (rd_data)
    );

    always_comb begin
        next_val2 = rb_data;
        case (op_src2(opc))
            SRC2_IMM:  next_val2 = {{(XLEN-OFF_W){f_off[OFF_W-1]}}, f_off};
            SRC2_ZERO: next_val2 = '0;
            default:   next_val2 = rb_data;
        endcase
    end

    // A bundle loaded during a mul hold stays hidden until the hold expires,
    // so the instruction following a mul surfaces exactly after the mul's 3 ALU cycles.
    assign busy        = (hold_cnt != 2'd0);
    assign out_valid_o = vld_q && !busy;
    assign in_ready_o  = !busy && !flush_i && (!out_valid_o || out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign handshake   = out_valid_o && out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt     <= 2'd0;
            vld_q        <= 1'b0;
            illegal_o    <= 1'b0;
            instr_o      <= '0;
            val1_o       <= '0;
            val2_o       <= '0;
            store_data_o <= '0;
            rd_o         <= '0;
            wb_en_o      <= 1'b0;
        end else begin
            if (handshake && (instr_o == OP_MUL)) begin
                hold_cnt <= MUL_HOLD;
            end else if (busy) begin
                hold_cnt <= hold_cnt - 2'd1;
            end

            // in_ready_o is low under flush, so an illegal opcode cannot be
            // flagged in a flush cycle.
            illegal_o <= accept && !op_legal(opc);

            if (flush_i) begin
                vld_q <= 1'b0;
            end else if (accept) begin
                vld_q <= op_legal(opc);
                if (op_legal(opc)) begin
                    instr_o      <= opc;
                    val1_o       <= ra_data;
                    val2_o       <= next_val2;
                    store_data_o <= rd_data;
                    rd_o         <= f_rd;
                    wb_en_o      <= op_wb_en(opc);
                end
            end else if (handshake) begin
                vld_q <= 1'b0;
            end
        end
    end

endmodule
